// File: rtl/milano_pkg.sv
// Shared milano fetch-path definitions.
// Contents:
//   imem_state_e   - instruction-memory responder FSM states
//   IMEM_ERR_RDATA - data word returned with an errored fetch
package milano_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] IMEM_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_array.sv
// Synchronous 1R1W word store for the instruction memory.
// Ports:
//   clk_i, rst_ni       - clock, async active-low reset (read register only)
//   re_i, raddr_i       - read enable / word index; data lands in rdata_o after the edge
//   clr_i               - load the error word into rdata_o instead of reading the store
//   rdata_o             - registered read data, held between reads
//   we_i, waddr_i, wdata_i - load-port write
// A read and a write of the same word on one edge return the old contents.
module instr_mem_array
  import milano_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           re_i,
  input  logic                           clr_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
  output logic [31:0]                    rdata_o,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  logic [31:0]                    wdata_i
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Store write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  // Read register: non-blocking semantics give read-before-write on a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_r <= IMEM_ERR_RDATA;
    end else if (clr_i) begin
      rdata_r <= IMEM_ERR_RDATA;
    end else if (re_i) begin
      rdata_r <= mem_r[raddr_i];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata_o = rdata_r;

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder for the milano fetch path.
// Accepts byte-address fetches, reads the word store and returns one in-order
// response per accepted request after WAIT_STATES extra cycles.
// Ports:
//   clk_i, rst_ni        - clock, async active-low reset
//   req_i, addr_i, gnt_o - fetch request handshake (accept = req_i && gnt_o)
//   rvalid_o, rdata_o, err_o - one-cycle response; err_o flags misaligned/out-of-range
//   we_i, waddr_i, wdata_i   - store load port
module instr_mem_resp
  import milano_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  input  logic [31:0]                    addr_i,
  output logic                           gnt_o,
  output logic                           rvalid_o,
  output logic [31:0]                    rdata_o,
  output logic                           err_o,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  logic [31:0]                    wdata_i
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam int          CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  // Span is computed in 33 bits so a store reaching the top of the address map still compares correctly.
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

  imem_state_e       state_r, state_n_s;
  logic [CNT_W-1:0]  cnt_r, cnt_n_s;
  logic              err_r;
  logic              gnt_s;
  logic              accept_s;
  logic              err_s;
  logic [31:0]       offset_s;
  logic [AW-1:0]     raddr_s;

  // Range/alignment check; the word index is only meaningful when err_s is low.
  assign offset_s = addr_i - BASE_ADDR;
  assign err_s    = (addr_i[1:0] != 2'b00) || (addr_i < BASE_ADDR) ||
                    ({1'b0, offset_s} >= SPAN);
  assign raddr_s  = offset_s[AW+1:2];

  // Grant depends only on the state register (and is forced low during reset).
  assign gnt_s    = rst_ni && (state_r != WAIT);
  assign accept_s = req_i && gnt_s;

  assign gnt_o    = gnt_s;
  assign rvalid_o = (state_r == RESP);
  assign err_o    = err_r;

  instr_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .re_i    (accept_s && !err_s),
    .clr_i   (accept_s && err_s),
    .raddr_i (raddr_s),
    .rdata_o (rdata_o),
    .we_i    (we_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i)
  );

  // State, wait counter and error flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      err_r   <= accept_s ? err_s : err_r;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept_s) begin
          if (WAIT_STATES == 0) begin
            state_n_s = RESP;
          end else begin
            state_n_s = WAIT;
            cnt_n_s   = CNT_W'(WAIT_STATES);
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      WAIT: begin
        cnt_n_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_n_s = RESP;
        end else begin
          state_n_s = WAIT;
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_mem_resp.sv
// Bench for instr_mem_resp: three instances (WAIT_STATES 0/3/2, two base
// addresses) checked against a queue-based reference of expected responses.
module tb_instr_mem_resp;

  localparam int          DEPTH = 16;
  localparam int          WS    [3] = '{0, 3, 2};
  localparam logic [31:0] BASES [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_1000};

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic [31:0] addr   [3];
  logic        we     [3];
  logic [3:0]  waddr  [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [31:0] rdata  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_mem_resp #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASES[g]),
      .WAIT_STATES (WS[g])
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req[g]),
      .addr_i   (addr[g]),
      .gnt_o    (gnt[g]),
      .rvalid_o (rvalid[g]),
      .rdata_o  (rdata[g]),
      .err_o    (err[g]),
      .we_i     (we[g]),
      .waddr_i  (waddr[g]),
      .wdata_i  (wdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          cur   = 0;
  rsp_t        q[$];
  logic [31:0] mm [3][DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", tag, cur, cyc, obs, exp_v);
    end
  endtask

  // Expected {err, data} for a fetch, straight from the address rules.
  function automatic logic [32:0] ref_fetch(input int i, input logic [31:0] a);
    longint aa;
    longint base;
    aa   = longint'(a);
    base = longint'(BASES[i]);
    if (a[1:0] != 2'b00 || aa < base || aa >= base + 4 * DEPTH)
      return {1'b1, 32'h0000_0000};
    return {1'b0, mm[i][int'((aa - base) >> 2)]};
  endfunction

  // One clock cycle of the current instance: check outputs, update model, advance.
  task automatic tick();
    logic        exp_g;
    logic        exp_v;
    logic [32:0] r;
    #1;
    exp_g = 1'b1;
    foreach (q[k]) if (q[k].due > cyc) exp_g = 1'b0;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    check_eq("gnt", 32'(gnt[cur]), 32'(exp_g));
    check_eq("rvalid", 32'(rvalid[cur]), 32'(exp_v));
    if (exp_v) begin
      check_eq("rdata", rdata[cur], q[0].d);
      check_eq("err", 32'(err[cur]), 32'(q[0].e));
      void'(q.pop_front());
    end
    if (req[cur] && exp_g) begin
      r = ref_fetch(cur, addr[cur]);
      q.push_back('{cyc + 1 + WS[cur], r[32], r[31:0]});
    end
    if (we[cur]) mm[cur][waddr[cur]] = wdata[cur];
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      req[i]   = 1'b0;
      addr[i]  = 32'h0000_0000;
      we[i]    = 1'b0;
      waddr[i] = 4'h0;
      wdata[i] = 32'h0000_0000;
    end
  endtask

  task automatic drain();
    int n;
    req[cur] = 1'b0;
    we[cur]  = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    check_eq("drain", 32'(q.size()), 32'd0);
    tick();
  endtask

  task automatic fetch(input logic [31:0] a);
    req[cur]  = 1'b1;
    addr[cur] = a;
    tick();
    req[cur]  = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int i);
    logic [31:0] b;
    b = BASES[i];
    case ($urandom_range(0, 5))
      0, 1, 2: return b + 32'(4 * $urandom_range(0, DEPTH - 1));
      3:       return b + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      4:       return b - 32'(4 * $urandom_range(1, 4));
      default: return b + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
    endcase
  endfunction

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      check_eq("rst_gnt", 32'(gnt[i]), 32'd0);
      check_eq("rst_rvalid", 32'(rvalid[i]), 32'd0);
      check_eq("rst_err", 32'(err[i]), 32'd0);
      check_eq("rst_rdata", rdata[i], 32'h0000_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      check_eq("gnt_after_rst", 32'(gnt[i]), 32'd1);
    end

    // Preload every instance through the load port.
    for (int i = 0; i < 3; i++) begin
      cur = i;
      for (int w = 0; w < DEPTH; w++) begin
        we[i]    = 1'b1;
        waddr[i] = 4'(w);
        wdata[i] = 32'h0000_0013 + 32'(w);
        tick();
      end
      we[i] = 1'b0;
    end

    // Zero wait states: back-to-back fetches, then error cases.
    cur = 0;
    req[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addr[0] = 32'(4 * k);
      tick();
    end
    drain();
    fetch(32'h0000_0002);
    drain();
    fetch(32'(4 * DEPTH));
    drain();

    // Same-edge load-port write and fetch of word 1: old data first, new data next.
    req[0] = 1'b1; addr[0] = 32'h0000_0004;
    we[0] = 1'b1; waddr[0] = 4'h1; wdata[0] = 32'hDEAD_BEEF;
    tick();
    we[0] = 1'b0;
    tick();
    drain();
    check_eq("collision_model", mm[0][1], 32'hDEAD_BEEF);

    // Three wait states: single fetch of word 1.
    cur = 1;
    fetch(BASES[1] + 32'h4);
    drain();

    // Reset while a two-wait-state response is pending.
    cur = 2;
    fetch(BASES[2] + 32'h8);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_gnt", 32'(gnt[2]), 32'd0);
    check_eq("midrst_rvalid", 32'(rvalid[2]), 32'd0);
    check_eq("midrst_err", 32'(err[2]), 32'd0);
    check_eq("midrst_rdata", rdata[2], 32'h0000_0000);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    // Randomised traffic per instance, writes mixed in.
    for (int i = 0; i < 3; i++) begin
      cur = i;
      for (int k = 0; k < 200; k++) begin
        req[i]   = ($urandom_range(0, 9) < 7);
        addr[i]  = rand_addr(i);
        we[i]    = ($urandom_range(0, 9) < 3);
        waddr[i] = 4'($urandom_range(0, DEPTH - 1));
        wdata[i] = $urandom;
        tick();
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_resp.md
# instr_mem_resp

Instruction-memory responder for the milano core fetch path. Accepts 32-bit byte-address fetch requests from the fetch stage, reads a word-organised instruction store and returns one response per accepted request, in order. Supports a configurable number of wait states and flags misaligned or out-of-range fetches. A side write port loads the store for boot images and testbench preloading.

## Interface
- DEPTH_WORDS, 1024: instruction store depth in 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0: extra cycles between request accept and response; range 0..15.

- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- req_i  in  1  fetch request valid.
- addr_i  in  32  fetch byte address; sampled when the request is accepted.
- gnt_o  out  1  request accepted this cycle when req_i && gnt_o.
- rvalid_o  out  1  response valid; one-cycle pulse per accepted request.
- rdata_o  out  32  instruction word; meaningful only while rvalid_o is high.
- err_o  out  1  fetch error; qualified by rvalid_o.
- we_i  in  1  load-port write enable.
- waddr_i  in  $clog2(DEPTH_WORDS)  load-port word index.
- wdata_i  in  32  load-port write data.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - gnt_o = 1 in IDLE and RESP; gnt_o = 0 in WAIT and while rst_ni is low.
- Accept in IDLE or RESP:
  - Latch the error flag and the read data.
  - WAIT_STATES == 0: next state is RESP.
  - Otherwise: next state is WAIT, with the counter loaded to WAIT_STATES.
- WAIT:
  - Decrement the counter every cycle.
  - When the counter equals 1, next state is RESP.
- RESP:
  - rvalid_o = 1, driving the latched rdata_o and err_o.
  - If a request is accepted in the same cycle, follow the accept rule above. Otherwise, next state is IDLE.
- Error when addr_i[1:0] != 0, or addr_i < BASE_ADDR, or addr_i >= BASE_ADDR + DEPTH_WORDS*4.
  - Response has err_o = 1 and rdata_o = 32'h0.
  - No store access is made.
- Word index = (addr_i - BASE_ADDR) >> 2, truncated to $clog2(DEPTH_WORDS) bits after the range check.
- Store read happens on the accepting edge. The response data does not change if the store is written while the response is in WAIT.
- Load-port write in the same cycle as a read of the same word: the read returns the old data.
- Store contents are not reset.
- Reset mid-operation: any pending response is discarded and no rvalid_o is issued.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - rvalid_o 0, err_o 0, rdata_o 32'h0.
  - gnt_o 0 while in reset, 1 from the first cycle after release.
- Latency: a request accepted at edge N gives rvalid_o high in cycle N+1+WAIT_STATES.
- Throughput:
  - WAIT_STATES == 0: one response per cycle when back-to-back, since gnt_o stays high in RESP.
  - Otherwise: one response per WAIT_STATES+1 cycles.
- rvalid_o is never asserted for two consecutive cycles for the same request.
- The counter is $clog2(WAIT_STATES+1) bits wide, with a minimum of 1.
- gnt_o is combinational from the state register only. It has no path from req_i.

## Structure
- Shared package milano_pkg holds:
  - the imem_state_e typedef (IDLE, WAIT, RESP);
  - the constant IMEM_ERR_RDATA = 32'h0.
- Sub-module instr_mem_array: synchronous 1R1W word store, parameter DEPTH_WORDS.
  - Read is registered on the edge, read-before-write on a same-address collision.
  - It keeps the FSM free of inference details.
- Top level contains the FSM, the wait counter, the range/alignment check and the response registers.

## Test plan
- Preload words 0..3 with 32'h0000_0013 + i; WAIT_STATES = 0; req_i held high with addr_i 0, 4, 8, 12 on consecutive cycles -> four back-to-back rvalid_o pulses returning 32'h13, 14, 15, 16, err_o = 0.
- WAIT_STATES = 3; one request at addr_i 4 -> gnt_o low for cycles N+1..N+3; rvalid_o only in cycle N+4, rdata_o = 32'h14.
- addr_i = 32'h0000_0002 -> err_o = 1, rdata_o = 0. addr_i = DEPTH_WORDS*4 -> err_o = 1.
- Load-port write of 32'hDEAD_BEEF to word 1 on the same edge that accepts a fetch of addr 4 -> response is the old 32'h14; the next fetch of addr 4 returns 32'hDEAD_BEEF.
- WAIT_STATES = 2; assert rst_ni low during WAIT -> no rvalid_o afterwards; outputs at reset values; gnt_o = 1 on the first cycle after release.
